// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel enable, scan counters, aligned syncs, frame strobe
// and final blanking of the renderer colour before the DAC pins.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       update_signal,
    output logic [2:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_tick_d;
    logic             r_update;
    logic [2:0]       r_rgb;

    logic             w_p_tick;
    logic             w_h_wrap;
    logic             w_video_on;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;

    // The reset term keeps p_tick low while held, which matters when CLK_DIV==1.
    always_comb begin
        w_p_tick   = reset && (r_div == DIV_LAST);
        w_h_wrap   = (r_h == H_LAST);
        w_h_next   = r_h;
        w_v_next   = r_v;
        if (w_p_tick) begin
            w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
            if (w_h_wrap) begin
                w_v_next = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
            end
        end
        w_video_on = (r_h < H_VIS) && (r_v < V_VIS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_tick_d <= 1'b0;
            r_update <= 1'b0;
            r_rgb    <= 3'b000;
        end else begin
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_h      <= w_h_next;
            r_v      <= w_v_next;
            // Syncs decode the next counter values so they change together with pixel_x/y.
            r_hsync  <= !((w_h_next >= HS_START) && (w_h_next <= HS_END));
            r_vsync  <= !((w_v_next >= VS_START) && (w_v_next <= VS_END));
            r_tick_d <= w_p_tick;
            // r_tick_d marks the first clk after a counter move, so one pulse per frame.
            r_update <= r_tick_d && (r_h == 10'd0) && (r_v == V_VIS);
            r_rgb    <= w_video_on ? rgb_in : 3'b000;
        end
    end

    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign video_on      = w_video_on;
    assign p_tick        = w_p_tick;
    assign pixel_x       = r_h;
    assign pixel_y       = r_v;
    assign update_signal = r_update;
    assign rgb_out       = r_rgb;

endmodule
